serial_subtractor: RTL and testbench

- Bit-serial multi-bit subtractor that computes a - b - bin one bit per clock, LSB first.
- Sits directly upstream of the team's full_subtractor cell (ports a, b, c, diff, borrow) and instantiates exactly one of it.
- The block feeds the cell one operand bit pair plus a registered borrow each cycle, and collects the cell's diff and borrow.
- Used where area matters more than latency; results come back through a start/done handshake.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full_subtractor cell. Results are returned through a
// start/done handshake and held until the next operation completes.
//
// Handshake: start is sampled only in IDLE; an accepted start captures a, b
// and bin. busy is high in RUN and DONE. done pulses for exactly one cycle,
// and diff/borrow_out are valid from that cycle until the next operation
// completes. A start presented while busy is ignored and is not queued.

// One-bit full subtractor: diff = a ^ b ^ c, borrow = (a < b + c).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b ^ c;
    assign borrow = (~a & (b | c)) | (b & c);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       o_dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_borrow_out;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic             w_cell_diff;
    logic             w_cell_borrow;
    logic [WIDTH-1:0] w_next_diff;

    // The only arithmetic in the block: one bit pair plus the running borrow.
    full_subtractor u_cell (
        .a      (r_a_sh[0]),
        .b      (r_b_sh[0]),
        .c      (r_brw),
        .diff   (w_cell_diff),
        .borrow (w_cell_borrow)
    );

    // The new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_next_diff = {w_cell_diff, r_diff_sh[WIDTH-1:1]};

    // Control FSM with registered outputs; diff only changes when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_diff_sh    <= '0;
            r_diff       <= '0;
            r_brw        <= 1'b0;
            r_borrow_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff_sh <= w_next_diff;
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_brw     <= w_cell_borrow;
                    r_cnt     <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_diff       <= w_next_diff;
                        r_borrow_out <= w_cell_borrow;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign diff        = r_diff;
    assign borrow_out  = r_borrow_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, randomized operations against
// a plain-arithmetic reference, protocol corner cases, and an exhaustive
// sweep of a 3-bit instance.
module tb_serial_subtractor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8-bit instance
    logic       s8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8;
    logic [7:0] d8;
    logic [1:0] st8;

    // 3-bit instance
    logic       s3, bin3;
    logic [2:0] a3, b3;
    logic       busy3, done3, bo3;
    logic [2:0] d3;
    logic [1:0] st3;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(d8), .borrow_out(bo8), .o_dbg_state(st8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(d3), .borrow_out(bo3), .o_dbg_state(st3)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction reduced mod 2^w; borrow iff negative.
    function automatic void model(input int w, input int a, input int b, input int bin,
                                  output logic [31:0] d, output logic bo);
        int r;
        r  = a - b - bin;
        bo = (r < 0);
        d  = 32'((r + (1 << w)) % (1 << w));
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one start, then waits for done; lat counts negedges after the accept edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        lat = 1;
        check("busy_rise8", {31'd0, busy8}, 32'd1);
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) begin
            total++; bad++;
            $display("FAIL timeout8: got no done expected done within 64 cycles");
        end
        d = d8; bo = bo8;
        @(negedge clk);
        check("done_pulse8", {30'd0, done8, busy8}, 32'd0);
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic bin,
                       output logic [2:0] d, output logic bo, output int lat);
        @(negedge clk);
        a3 = a; b3 = b; bin3 = bin; s3 = 1'b1;
        @(negedge clk);
        s3 = 1'b0;
        lat = 1;
        while (!done3 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!done3) begin
            total++; bad++;
            $display("FAIL timeout3: got no done expected done within 64 cycles");
        end
        d = d3; bo = bo3;
        @(negedge clk);
        check("done_pulse3", {30'd0, done3, busy3}, 32'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0]  d;
        logic        bo;
        int          lat;
        logic [31:0] md;
        logic        mbo;
        logic [7:0]  ra, rb;
        logic        rbin;
        int          pulses[$];
        int          n;
        logic        seen;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bo: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'h00, bin: 1'b0, d: 8'hFF, bo: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h00, bin: 1'b1, d: 8'h7F, bo: 1'b0};

        // Reset held with a start pending and a non-zero operand.
        rst = 1'b1; s8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
        s3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_diff", {24'd0, d8}, 32'd0);
        check("rst_borrow", {31'd0, bo8}, 32'd0);
        check("rst_state", {30'd0, st8}, 32'd0);
        rst = 1'b0; s8 = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {31'd0, busy8}, 32'd0);

        // Directed table.
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat);
            check($sformatf("vec%0d_diff", i), {24'd0, d}, {24'd0, vecs[i].d});
            check($sformatf("vec%0d_borrow", i), {31'd0, bo}, {31'd0, vecs[i].bo});
            check($sformatf("vec%0d_lat", i), lat, 32'd9);
        end

        // Start re-pulsed and operands changed mid-RUN; previous result holds meanwhile.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_prev_diff", {24'd0, d8}, 32'h7F);
        check("hold_prev_borrow", {31'd0, bo8}, 32'd0);
        s8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
        repeat (2) @(negedge clk);
        s8 = 1'b0;
        lat = 6;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("midrun_lat", lat, 32'd9);
        check("midrun_diff", {24'd0, d8}, 32'h1E);
        check("midrun_borrow", {31'd0, bo8}, 32'd0);
        repeat (3) @(negedge clk);
        check("midrun_no_requeue", {31'd0, busy8}, 32'd0);

        // Start held continuously: one result every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; s8 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done8) begin
                pulses.push_back(cyc);
                check("held_diff", {24'd0, d8}, 32'h0F);
            end
        end
        s8 = 1'b0;
        check("held_count", pulses.size(), 32'd4);
        if (pulses.size() > 0) check("held_first", pulses[0], 32'd9);
        for (int i = 1; i < pulses.size(); i++)
            check("held_period", pulses[i] - pulses[i-1], 32'd10);
        n = 0;
        while (busy8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held_stop", {31'd0, busy8}, 32'd0);

        // Reset after 4 RUN cycles discards the operation.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy8}, 32'd0);
        check("mid_rst_done", {31'd0, done8}, 32'd0);
        check("mid_rst_diff", {24'd0, d8}, 32'd0);
        check("mid_rst_borrow", {31'd0, bo8}, 32'd0);
        check("mid_rst_state", {30'd0, st8}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("mid_rst_quiet", {31'd0, seen}, 32'd0);
        op8(8'h33, 8'h11, 1'b0, d, bo, lat);
        check("after_rst_diff", {24'd0, d}, 32'h22);
        check("after_rst_borrow", {31'd0, bo}, 32'd0);
        check("after_rst_lat", lat, 32'd9);

        // Randomized operations against the reference.
        for (int i = 0; i < 30; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            model(8, int'(ra), int'(rb), int'(rbin), md, mbo);
            op8(ra, rb, rbin, d, bo, lat);
            check($sformatf("rand%0d_diff", i), {24'd0, d}, md);
            check($sformatf("rand%0d_borrow", i), {31'd0, bo}, {31'd0, mbo});
        end

        // Exhaustive 3-bit sweep.
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [2:0] d3v;
                    model(3, ia, ib, ic, md, mbo);
                    op3(3'(ia), 3'(ib), 1'(ic), d3v, bo, lat);
                    check("w3_diff", {29'd0, d3v}, md);
                    check("w3_borrow", {31'd0, bo}, {31'd0, mbo});
                    check("w3_lat", lat, 32'd4);
                end
            end
        end

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
